// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Generates a one-clk-wide clock-enable for the 8-bit CPU datapath from
//   either the divided slow clock (free-run) or a debounced step button
//   (single-step), with a sticky halt requested by the CPU control unit.
//   slow_clk is sampled as data and never used as a clock.
//
// Ports:
//   clk        50 MHz system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   slow_clk   divided clock, asynchronous data input
//   btn_step   raw step pushbutton, active-high, bouncy, asynchronous
//   sw_run     run/step switch, asynchronous level, 1 = free-run
//   halt_req   synchronous halt request, level
//   cpu_ce     CPU clock-enable, one clk cycle per step
//   mode       FSM state: 00 STEP, 01 RUN, 10 HALT
//   step_count cpu_ce pulses issued since reset, wraps at 8 bits
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       btn_step,
  input  logic       sw_run,
  input  logic       halt_req,
  output logic       cpu_ce,
  output logic [1:0] mode,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  state_t          state;
  logic            slow_s1, slow_s2, slow_s3;
  logic            btn_s1, btn_sync;
  logic            run_s1, run_sync;
  logic [DB_W-1:0] db_cnt;
  logic            btn_db, btn_db_prev;
  logic            slow_rise;
  logic            press;

  assign slow_rise = slow_s2 & ~slow_s3;
  assign press     = btn_db & ~btn_db_prev;
  assign mode      = state;

  // Synchronizers and button debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_s1     <= 1'b0;
      slow_s2     <= 1'b0;
      slow_s3     <= 1'b0;
      btn_s1      <= 1'b0;
      btn_sync    <= 1'b0;
      run_s1      <= 1'b0;
      run_sync    <= 1'b0;
      db_cnt      <= '0;
      btn_db      <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      slow_s1     <= slow_clk;
      slow_s2     <= slow_s1;
      slow_s3     <= slow_s2;
      btn_s1      <= btn_step;
      btn_sync    <= btn_s1;
      run_s1      <= sw_run;
      run_sync    <= run_s1;
      btn_db_prev <= btn_db;
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive
      // cycles of disagreement; any agreement restarts the window.
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Step FSM; halt_req overrides everything, including a coincident step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_STEP;
      cpu_ce     <= 1'b0;
      step_count <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (halt_req) begin
        state <= ST_HALT;
      end else begin
        unique case (state)
          ST_HALT: begin
            // The press that releases the halt does not itself step.
            if (press && !run_sync) state <= ST_STEP;
          end
          ST_STEP: begin
            if (run_sync) begin
              state <= ST_RUN;
            end else if (press) begin
              cpu_ce     <= 1'b1;
              step_count <= step_count + 8'd1;
            end
          end
          ST_RUN: begin
            if (!run_sync) begin
              state <= ST_STEP;
            end else if (slow_rise) begin
              cpu_ce     <= 1'b1;
              step_count <= step_count + 8'd1;
            end
          end
          default: state <= ST_STEP;
        endcase
      end
    end
  end

endmodule
